// File: rtl/sprite_arb_pkg.sv
// Shared types and helpers for the sprite ROM arbiter: FSM state type,
// round-robin pick function and the default tag id width.
package sprite_arb_pkg;

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} arb_state_t;

  localparam int MAX_REQ      = 8;
  localparam int NUM_REQ_DFLT = 4;
  localparam int ID_W         = $clog2(NUM_REQ_DFLT);

  // One-hot of the first set bit of req, searching circularly from ptr over
  // the first n positions; wrap is an explicit compare so any n in 2..8 works.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    int                 idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = {29'd0, ptr} + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[2:0]]) begin
          pick[idx[2:0]] = 1'b1;
          found          = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sprite_arb_tag_pipe.sv
// Valid/id shift register that tracks which requester owns each ROM read
// while it is in flight; synchronous clear drops every outstanding tag.
module sprite_arb_tag_pipe
  import sprite_arb_pkg::*;
#(
  parameter int DEPTH    = 1,
  parameter int TAG_ID_W = ID_W
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [TAG_ID_W-1:0] in_id,
  output logic                out_valid,
  output logic [TAG_ID_W-1:0] out_id
);

  logic [DEPTH-1:0]    r_valid;
  logic [TAG_ID_W-1:0] r_id [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      r_valid <= '0;
      for (int s = 0; s < DEPTH; s++) r_id[s] <= '0;
    end else begin
      r_valid[0] <= in_valid;
      r_id[0]    <= in_id;
      for (int s = 1; s < DEPTH; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_id[s]    <= r_id[s-1];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_id    = r_id[DEPTH-1];

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter with per-requester burst lock sharing one sprite ROM;
// tags each read and routes the returned palette index to its requester.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 2,
  parameter int ROM_LATENCY = 1,
  parameter int MAX_BURST   = 14
) (
  input  logic                        vga_clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]           rom_address,
  input  logic [DATA_W-1:0]           rom_q,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output arb_state_t                  dbg_state
);

  localparam int PW    = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Handshake: req[i] (with its address) is held until gnt[i]=1 in the same
  // cycle; that cycle the read is issued and the requester may move on.

  arb_state_t         r_state, w_state_nxt;
  logic [PW-1:0]      r_rr_ptr, w_ptr_nxt;
  logic [PW-1:0]      r_owner, w_owner_nxt;
  logic [CNT_W-1:0]   r_burst, w_burst_nxt;
  logic [MAX_REQ-1:0] w_req_full, w_pick_full;
  logic [PW-1:0]      w_pick_id, w_issue_id, w_tag_id;
  logic               w_issue, w_tag_valid;

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    w_req_full               = '0;
    w_req_full[NUM_REQ-1:0]  = req;
    w_pick_full              = rr_pick(w_req_full, 3'(r_rr_ptr), NUM_REQ);
    w_pick_id                = '0;
    for (int k = 0; k < MAX_REQ; k++)
      if (w_pick_full[k]) w_pick_id = PW'(k);
    gnt         = '0;
    w_issue     = 1'b0;
    w_issue_id  = w_pick_id;
    w_state_nxt = r_state;
    w_ptr_nxt   = r_rr_ptr;
    w_owner_nxt = r_owner;
    w_burst_nxt = r_burst;
    if (!reset) begin
      case (r_state)
        ARB: begin
          if (|req) begin
            w_issue        = 1'b1;
            gnt[w_pick_id] = 1'b1;
            w_ptr_nxt      = inc_wrap(w_pick_id);
            if (req_lock[w_pick_id]) begin
              w_state_nxt = LOCK;
              w_owner_nxt = w_pick_id;
              w_burst_nxt = CNT_W'(1);
            end
          end
        end
        LOCK: begin
          w_issue_id = r_owner;
          if (req[r_owner]) begin
            w_issue      = 1'b1;
            gnt[r_owner] = 1'b1;
            w_burst_nxt  = r_burst + 1'b1;
            // Exit grant still issues; owner loses priority on the way out.
            if (!req_lock[r_owner] || w_burst_nxt == CNT_W'(MAX_BURST)) begin
              w_state_nxt = ARB;
              w_ptr_nxt   = inc_wrap(r_owner);
            end
          end else begin
            w_state_nxt = ARB;
            w_ptr_nxt   = inc_wrap(r_owner);
          end
        end
        default: w_state_nxt = ARB;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state     <= ARB;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst     <= '0;
      rom_address <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_ptr_nxt;
      r_owner  <= w_owner_nxt;
      r_burst  <= w_burst_nxt;
      if (w_issue) rom_address <= req_addr[w_issue_id*ADDR_W +: ADDR_W];
    end
  end

  sprite_arb_tag_pipe #(
    .DEPTH    (ROM_LATENCY),
    .TAG_ID_W (PW)
  ) u_tag_pipe (
    .clk       (vga_clk),
    .clr       (reset),
    .in_valid  (w_issue),
    .in_id     (w_issue_id),
    .out_valid (w_tag_valid),
    .out_id    (w_tag_id)
  );

  // Tag leaves the pipe in the cycle rom_q belongs to it; capture both together.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= '0;
      if (w_tag_valid) begin
        rsp_valid[w_tag_id] <= 1'b1;
        rsp_data            <= rom_q;
        rsp_id              <= w_tag_id;
      end
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: latency-1 and latency-3 instances share the
// same requesters; a behavioural model is checked every cycle plus directed vectors.
module tb_sprite_rom_arbiter;
  import sprite_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 2;
  localparam int MB = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [N-1:0]      req, req_lock;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      gnt1, gnt3, rv1, rv3;
  logic [AW-1:0]     ra1, ra3;
  logic [DW-1:0]     q1, q3, rd1, rd3;
  logic [1:0]        rid1, rid3;
  arb_state_t        st1, st3;

  logic [DW-1:0]     mem [256];
  logic [AW-1:0]     a3_d1, a3_d2;

  assign q1 = mem[ra1];
  always @(posedge clk) begin
    a3_d1 <= ra3;
    a3_d2 <= a3_d1;
  end
  assign q3 = mem[a3_d2];

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(1), .MAX_BURST(MB)) dut1 (
    .vga_clk(clk), .reset(reset), .req(req), .req_lock(req_lock), .req_addr(req_addr),
    .gnt(gnt1), .rom_address(ra1), .rom_q(q1), .rsp_valid(rv1), .rsp_data(rd1),
    .rsp_id(rid1), .dbg_state(st1));

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(3), .MAX_BURST(MB)) dut3 (
    .vga_clk(clk), .reset(reset), .req(req), .req_lock(req_lock), .req_addr(req_addr),
    .gnt(gnt3), .rom_address(ra3), .rom_q(q3), .rsp_valid(rv3), .rsp_data(rd3),
    .rsp_id(rid3), .dbg_state(st3));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit run_cmp  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the ROM this cycle, from the arbitration rules.
  bit            m_lock;
  int            m_ptr, m_owner, m_cnt;
  logic [AW-1:0] m_addr;
  logic [4:0]    exp_q1[$];
  logic [4:0]    exp_q3[$];

  function automatic int model_grant();
    if (reset) return -1;
    if (m_lock) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  always @(posedge clk) begin : model
    int         g;
    logic [4:0] e;
    g = model_grant();
    if (reset) begin
      m_lock = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_addr = '0;
      exp_q1 = {};
      exp_q3 = {};
      repeat (2) exp_q1.push_front(5'd0);
      repeat (4) exp_q3.push_front(5'd0);
    end else begin
      e = 5'd0;
      if (g >= 0) begin
        e      = {1'b1, 2'(g), mem[addr_of(g)]};
        m_addr = addr_of(g);
      end
      exp_q1.push_front(e);
      exp_q3.push_front(e);
      void'(exp_q1.pop_back());
      void'(exp_q3.pop_back());
      if (m_lock) begin
        if (g < 0) begin
          m_lock = 0; m_ptr = (m_owner + 1) % N;
        end else begin
          m_cnt++;
          if (!req_lock[m_owner] || m_cnt == MB) begin
            m_lock = 0; m_ptr = (m_owner + 1) % N;
          end
        end
      end else if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (req_lock[g]) begin
          m_lock = 1; m_owner = g; m_cnt = 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int         g;
    logic [N-1:0] eg;
    logic [4:0] e1, e3;
    if (run_cmp) begin
      g  = model_grant();
      eg = (g >= 0) ? N'(1 << g) : '0;
      chk("gnt_l1", gnt1, eg);
      chk("gnt_l3", gnt3, eg);
      chk("addr_l1", ra1, m_addr);
      chk("addr_l3", ra3, m_addr);
      e1 = exp_q1[1];
      e3 = exp_q3[3];
      chk("rsp_valid_l1", rv1, e1[4] ? (32'd1 << e1[3:2]) : 32'd0);
      chk("rsp_valid_l3", rv3, e3[4] ? (32'd1 << e3[3:2]) : 32'd0);
      if (e1[4]) begin
        chk("rsp_data_l1", rd1, e1[1:0]);
        chk("rsp_id_l1", rid1, e1[3:2]);
      end
      if (e3[4]) begin
        chk("rsp_data_l3", rd3, e3[1:0]);
        chk("rsp_id_l3", rid3, e3[3:2]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_lock = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int exp_id;
    logic [DW-1:0] l3_data [3];
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom_range(0, 3));
    mem[8'h2A] = 2'b10;
    mem[8'h31] = 2'b01;
    mem[8'h32] = 2'b11;
    mem[8'h33] = 2'b00;
    l3_data[0] = 2'b01; l3_data[1] = 2'b11; l3_data[2] = 2'b00;

    // reset state; gnt stays low even with requests pending
    reset = 1'b1; req = 4'b1111; req_lock = '0; req_addr = '0;
    tick(); tick();
    neg();
    chk("rst_gnt", gnt1, 0);
    chk("rst_gnt3", gnt3, 0);
    chk("rst_addr", ra1, 0);
    chk("rst_valid", rv1, 0);
    chk("rst_data", rd1, 0);
    chk("rst_id", rid1, 0);
    run_cmp = 1'b1;
    tick();
    reset = 1'b0; req = '0;

    // single requester, latency 1
    req_addr = {8'h03, 8'h02, 8'h01, 8'h2A};
    req = 4'b0001;
    neg(); chk("t1_gnt", gnt1, 4'b0001);
    tick(); req = '0;
    neg(); chk("t1_addr", ra1, 8'h2A); chk("t1_novalid", rv1, 0);
    tick();
    neg(); chk("t1_valid", rv1, 4'b0001); chk("t1_data", rd1, 2'b10); chk("t1_id", rid1, 0);
    tick();

    // round robin, all requesting
    do_reset();
    req_addr = {8'h43, 8'h42, 8'h41, 8'h40};
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      neg(); chk("t2_rr", gnt1, 32'd1 << (c % 4));
      tick();
    end
    req = '0;
    repeat (5) tick();

    // lock burst capped at MAX_BURST, then priority moves past the owner
    do_reset();
    req = 4'b0111; req_lock = 4'b0010;
    for (int c = 0; c < 17; c++) begin
      exp_id = (c == 0) ? 0 : (c <= 14) ? 1 : (c == 15) ? 2 : 0;
      neg(); chk("t3_lock", gnt1, 32'd1 << exp_id);
      tick();
    end
    req = '0; req_lock = '0;
    repeat (3) tick();

    // early unlock on the 5th grant to requester 3
    do_reset();
    req = 4'b1010; req_lock = 4'b1000;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) req_lock = '0;
      exp_id = (c == 0 || c == 6) ? 1 : 3;
      neg(); chk("t4_unlock", gnt1, 32'd1 << exp_id);
      tick();
    end
    req = '0;
    repeat (3) tick();

    // reset while a read is in flight
    do_reset();
    req_addr = {8'h03, 8'h02, 8'h01, 8'h10};
    req = 4'b0001;
    neg(); chk("t5_gnt", gnt1, 4'b0001);
    tick();
    req = '0; reset = 1'b1;
    tick();
    reset = 1'b0;
    neg(); chk("t5_addr", ra1, 0); chk("t5_data", rd1, 0); chk("t5_id", rid1, 0);
    for (int c = 0; c < 4; c++) begin
      chk("t5_noresp_l1", rv1, 0);
      chk("t5_noresp_l3", rv3, 0);
      tick(); neg();
    end
    tick();
    req = 4'b1111;
    neg(); chk("t5_first", gnt1, 4'b0001);
    tick(); req = '0;
    repeat (5) tick();

    // latency-3 instance, back-to-back grants 0,1,2
    do_reset();
    req_addr = {8'h00, 8'h33, 8'h32, 8'h31};
    req = 4'b0111;
    neg(); chk("t6_gnt0", gnt3, 4'b0001); tick();
    req = 4'b0110;
    neg(); chk("t6_gnt1", gnt3, 4'b0010); tick();
    req = 4'b0100;
    neg(); chk("t6_gnt2", gnt3, 4'b0100); tick();
    req = '0;
    neg(); chk("t6_early", rv3, 0); tick();
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("t6_valid", rv3, 32'd1 << k);
      chk("t6_data", rd3, l3_data[k]);
      chk("t6_id", rid3, k);
      tick();
    end
    repeat (3) tick();

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one single-port sprite ROM (palette-index output) among up to NUM_REQ sprite draw engines: player ship, enemy ships, bullets.
- Round-robin arbitration with an optional per-requester lock, so one engine can fetch a full sprite row back-to-back.
- Tags each ROM read and returns the data to the issuing requester after the fixed ROM latency.
- Sits between the sprite draw engines and the shared ROM; feeds the palette/compositor path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, ROM address width.
- DATA_W, 2, ROM word width (palette index).
- ROM_LATENCY, 1, cycles from rom_address register update to valid rom_q (1..3).
- MAX_BURST, 14, maximum consecutive grants to one locked owner (one sprite row).

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester read request; held until granted.
- req_lock  in  NUM_REQ  requester wants to keep ownership after this grant.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted req.
- rom_address  out  ADDR_W  registered address to the shared ROM.
- rom_q  in  DATA_W  ROM data, valid ROM_LATENCY cycles after its address.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: data for requester i.
- rsp_data  out  DATA_W  registered copy of rom_q.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester owning rsp_data.

Behaviour:
- Reset (sync, high): state=ARB, rr_ptr=0, owner=0, burst_cnt=0, rom_address=0, tag pipeline cleared, rsp_valid=0, rsp_data=0, rsp_id=0. gnt=0 while reset is high.
- A read is issued in a cycle where gnt[i]=1. At that posedge:
  - rom_address <= req_addr[i];
  - tag {valid=1, id=i} enters a shift pipeline of depth ROM_LATENCY.
- Response: tag exits the pipeline in the same cycle rom_q is valid for that address. On the next posedge rsp_data<=rom_q, rsp_id<=id, rsp_valid<=onehot(id).
- Total latency gnt to rsp_valid = ROM_LATENCY+1 cycles. One grant per cycle maximum, so full throughput is 1 read/cycle.
- No grant: pipeline shifts in valid=0, and rom_address holds its value.
- State ARB:
  - gnt = first set bit of req, searching circularly from rr_ptr.
  - On a grant to i: rr_ptr <= (i+1) mod NUM_REQ.
  - If req_lock[i]=1: go to LOCK, owner<=i, burst_cnt<=1.
- State LOCK:
  - gnt = onehot(owner) iff req[owner]; all other requesters see gnt=0.
  - Each grant increments burst_cnt.
  - Return to ARB, rr_ptr <= (owner+1) mod NUM_REQ, when any of:
    - req_lock[owner]=0 in a granted cycle (that grant still issues);
    - req[owner]=0;
    - burst_cnt reaches MAX_BURST after the current grant.
  - The grant in the exit cycle still issues.
- No req set: gnt=0, state and rr_ptr unchanged.
- Simultaneous requests: exactly one grant; the others stay pending. Requesters hold req and addr until granted.
- Reset mid-operation: in-flight tags are discarded; no rsp_valid is issued for reads granted before reset.
- NUM_REQ not a power of two: rr_ptr wrap uses an explicit compare, not bit truncation.

Decomposition:
- Package sprite_arb_pkg holds:
  - typedef arb_state_t {ARB, LOCK};
  - function rr_pick(req, ptr) returning a one-hot vector;
  - localparam ID_W = $clog2(NUM_REQ).
- Sub-module sprite_arb_tag_pipe holds the ROM_LATENCY-deep valid/id shift register with synchronous clear.

Test Plan:
- Single requester: req=4'b0001, addr=8'h2A, ROM model latency 1 with mem[2A]=2'b10 → gnt[0] same cycle; rom_address=8'h2A next cycle; rsp_valid=4'b0001, rsp_data=2'b10, rsp_id=0 two cycles after gnt.
- Round-robin fairness: req=4'b1111 held constant, no lock → grants 0,1,2,3,0,… one per cycle; each rsp_id matches its grant order.
- Lock burst: req1 with lock held for 20 cycles, req0 and req2 also asserted → 14 consecutive grants to 1, then release; next grant goes to 2 (rr_ptr=2), not 0.
- Early unlock: req3 locks, drops req_lock on its 5th grant → 5 grants to 3, cycle 6 grants the next RR requester.
- Reset mid-flight: grant addr 8'h10 then assert reset the following cycle → no rsp_valid afterwards; all outputs 0; first grant after reset goes to requester 0.
- Latency 3 build (ROM_LATENCY=3): back-to-back grants to 0,1,2 → rsp_valid at gnt+4 for each, in order, data matching each address.
